// File: rtl/sub_bytes_engine_pkg.sv
// Shared AES definitions: byte count, 128-bit state type and the
// sub_bytes_engine FSM encoding.
package sub_bytes_engine_pkg;

    localparam int AES_BYTES = 16;

    typedef logic [8*AES_BYTES-1:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/sBox.sv
// FIPS-197 forward S-box as a purely combinational 256-entry lookup.
module sBox (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    always_comb begin
        data_out = 8'h00;
        case (data_in)
            8'h00: data_out = 8'h63; 8'h01: data_out = 8'h7c; 8'h02: data_out = 8'h77; 8'h03: data_out = 8'h7b; 8'h04: data_out = 8'hf2; 8'h05: data_out = 8'h6b; 8'h06: data_out = 8'h6f; 8'h07: data_out = 8'hc5;
            8'h08: data_out = 8'h30; 8'h09: data_out = 8'h01; 8'h0a: data_out = 8'h67; 8'h0b: data_out = 8'h2b; 8'h0c: data_out = 8'hfe; 8'h0d: data_out = 8'hd7; 8'h0e: data_out = 8'hab; 8'h0f: data_out = 8'h76;
            8'h10: data_out = 8'hca; 8'h11: data_out = 8'h82; 8'h12: data_out = 8'hc9; 8'h13: data_out = 8'h7d; 8'h14: data_out = 8'hfa; 8'h15: data_out = 8'h59; 8'h16: data_out = 8'h47; 8'h17: data_out = 8'hf0;
            8'h18: data_out = 8'had; 8'h19: data_out = 8'hd4; 8'h1a: data_out = 8'ha2; 8'h1b: data_out = 8'haf; 8'h1c: data_out = 8'h9c; 8'h1d: data_out = 8'ha4; 8'h1e: data_out = 8'h72; 8'h1f: data_out = 8'hc0;
            8'h20: data_out = 8'hb7; 8'h21: data_out = 8'hfd; 8'h22: data_out = 8'h93; 8'h23: data_out = 8'h26; 8'h24: data_out = 8'h36; 8'h25: data_out = 8'h3f; 8'h26: data_out = 8'hf7; 8'h27: data_out = 8'hcc;
            8'h28: data_out = 8'h34; 8'h29: data_out = 8'ha5; 8'h2a: data_out = 8'he5; 8'h2b: data_out = 8'hf1; 8'h2c: data_out = 8'h71; 8'h2d: data_out = 8'hd8; 8'h2e: data_out = 8'h31; 8'h2f: data_out = 8'h15;
            8'h30: data_out = 8'h04; 8'h31: data_out = 8'hc7; 8'h32: data_out = 8'h23; 8'h33: data_out = 8'hc3; 8'h34: data_out = 8'h18; 8'h35: data_out = 8'h96; 8'h36: data_out = 8'h05; 8'h37: data_out = 8'h9a;
            8'h38: data_out = 8'h07; 8'h39: data_out = 8'h12; 8'h3a: data_out = 8'h80; 8'h3b: data_out = 8'he2; 8'h3c: data_out = 8'heb; 8'h3d: data_out = 8'h27; 8'h3e: data_out = 8'hb2; 8'h3f: data_out = 8'h75;
            8'h40: data_out = 8'h09; 8'h41: data_out = 8'h83; 8'h42: data_out = 8'h2c; 8'h43: data_out = 8'h1a; 8'h44: data_out = 8'h1b; 8'h45: data_out = 8'h6e; 8'h46: data_out = 8'h5a; 8'h47: data_out = 8'ha0;
            8'h48: data_out = 8'h52; 8'h49: data_out = 8'h3b; 8'h4a: data_out = 8'hd6; 8'h4b: data_out = 8'hb3; 8'h4c: data_out = 8'h29; 8'h4d: data_out = 8'he3; 8'h4e: data_out = 8'h2f; 8'h4f: data_out = 8'h84;
            8'h50: data_out = 8'h53; 8'h51: data_out = 8'hd1; 8'h52: data_out = 8'h00; 8'h53: data_out = 8'hed; 8'h54: data_out = 8'h20; 8'h55: data_out = 8'hfc; 8'h56: data_out = 8'hb1; 8'h57: data_out = 8'h5b;
            8'h58: data_out = 8'h6a; 8'h59: data_out = 8'hcb; 8'h5a: data_out = 8'hbe; 8'h5b: data_out = 8'h39; 8'h5c: data_out = 8'h4a; 8'h5d: data_out = 8'h4c; 8'h5e: data_out = 8'h58; 8'h5f: data_out = 8'hcf;
            8'h60: data_out = 8'hd0; 8'h61: data_out = 8'hef; 8'h62: data_out = 8'haa; 8'h63: data_out = 8'hfb; 8'h64: data_out = 8'h43; 8'h65: data_out = 8'h4d; 8'h66: data_out = 8'h33; 8'h67: data_out = 8'h85;
            8'h68: data_out = 8'h45; 8'h69: data_out = 8'hf9; 8'h6a: data_out = 8'h02; 8'h6b: data_out = 8'h7f; 8'h6c: data_out = 8'h50; 8'h6d: data_out = 8'h3c; 8'h6e: data_out = 8'h9f; 8'h6f: data_out = 8'ha8;
            8'h70: data_out = 8'h51; 8'h71: data_out = 8'ha3; 8'h72: data_out = 8'h40; 8'h73: data_out = 8'h8f; 8'h74: data_out = 8'h92; 8'h75: data_out = 8'h9d; 8'h76: data_out = 8'h38; 8'h77: data_out = 8'hf5;
            8'h78: data_out = 8'hbc; 8'h79: data_out = 8'hb6; 8'h7a: data_out = 8'hda; 8'h7b: data_out = 8'h21; 8'h7c: data_out = 8'h10; 8'h7d: data_out = 8'hff; 8'h7e: data_out = 8'hf3; 8'h7f: data_out = 8'hd2;
            8'h80: data_out = 8'hcd; 8'h81: data_out = 8'h0c; 8'h82: data_out = 8'h13; 8'h83: data_out = 8'hec; 8'h84: data_out = 8'h5f; 8'h85: data_out = 8'h97; 8'h86: data_out = 8'h44; 8'h87: data_out = 8'h17;
            8'h88: data_out = 8'hc4; 8'h89: data_out = 8'ha7; 8'h8a: data_out = 8'h7e; 8'h8b: data_out = 8'h3d; 8'h8c: data_out = 8'h64; 8'h8d: data_out = 8'h5d; 8'h8e: data_out = 8'h19; 8'h8f: data_out = 8'h73;
            8'h90: data_out = 8'h60; 8'h91: data_out = 8'h81; 8'h92: data_out = 8'h4f; 8'h93: data_out = 8'hdc; 8'h94: data_out = 8'h22; 8'h95: data_out = 8'h2a; 8'h96: data_out = 8'h90; 8'h97: data_out = 8'h88;
            8'h98: data_out = 8'h46; 8'h99: data_out = 8'hee; 8'h9a: data_out = 8'hb8; 8'h9b: data_out = 8'h14; 8'h9c: data_out = 8'hde; 8'h9d: data_out = 8'h5e; 8'h9e: data_out = 8'h0b; 8'h9f: data_out = 8'hdb;
            8'ha0: data_out = 8'he0; 8'ha1: data_out = 8'h32; 8'ha2: data_out = 8'h3a; 8'ha3: data_out = 8'h0a; 8'ha4: data_out = 8'h49; 8'ha5: data_out = 8'h06; 8'ha6: data_out = 8'h24; 8'ha7: data_out = 8'h5c;
            8'ha8: data_out = 8'hc2; 8'ha9: data_out = 8'hd3; 8'haa: data_out = 8'hac; 8'hab: data_out = 8'h62; 8'hac: data_out = 8'h91; 8'had: data_out = 8'h95; 8'hae: data_out = 8'he4; 8'haf: data_out = 8'h79;
            8'hb0: data_out = 8'he7; 8'hb1: data_out = 8'hc8; 8'hb2: data_out = 8'h37; 8'hb3: data_out = 8'h6d; 8'hb4: data_out = 8'h8d; 8'hb5: data_out = 8'hd5; 8'hb6: data_out = 8'h4e; 8'hb7: data_out = 8'ha9;
            8'hb8: data_out = 8'h6c; 8'hb9: data_out = 8'h56; 8'hba: data_out = 8'hf4; 8'hbb: data_out = 8'hea; 8'hbc: data_out = 8'h65; 8'hbd: data_out = 8'h7a; 8'hbe: data_out = 8'hae; 8'hbf: data_out = 8'h08;
            8'hc0: data_out = 8'hba; 8'hc1: data_out = 8'h78; 8'hc2: data_out = 8'h25; 8'hc3: data_out = 8'h2e; 8'hc4: data_out = 8'h1c; 8'hc5: data_out = 8'ha6; 8'hc6: data_out = 8'hb4; 8'hc7: data_out = 8'hc6;
            8'hc8: data_out = 8'he8; 8'hc9: data_out = 8'hdd; 8'hca: data_out = 8'h74; 8'hcb: data_out = 8'h1f; 8'hcc: data_out = 8'h4b; 8'hcd: data_out = 8'hbd; 8'hce: data_out = 8'h8b; 8'hcf: data_out = 8'h8a;
            8'hd0: data_out = 8'h70; 8'hd1: data_out = 8'h3e; 8'hd2: data_out = 8'hb5; 8'hd3: data_out = 8'h66; 8'hd4: data_out = 8'h48; 8'hd5: data_out = 8'h03; 8'hd6: data_out = 8'hf6; 8'hd7: data_out = 8'h0e;
            8'hd8: data_out = 8'h61; 8'hd9: data_out = 8'h35; 8'hda: data_out = 8'h57; 8'hdb: data_out = 8'hb9; 8'hdc: data_out = 8'h86; 8'hdd: data_out = 8'hc1; 8'hde: data_out = 8'h1d; 8'hdf: data_out = 8'h9e;
            8'he0: data_out = 8'he1; 8'he1: data_out = 8'hf8; 8'he2: data_out = 8'h98; 8'he3: data_out = 8'h11; 8'he4: data_out = 8'h69; 8'he5: data_out = 8'hd9; 8'he6: data_out = 8'h8e; 8'he7: data_out = 8'h94;
            8'he8: data_out = 8'h9b; 8'he9: data_out = 8'h1e; 8'hea: data_out = 8'h87; 8'heb: data_out = 8'he9; 8'hec: data_out = 8'hce; 8'hed: data_out = 8'h55; 8'hee: data_out = 8'h28; 8'hef: data_out = 8'hdf;
            8'hf0: data_out = 8'h8c; 8'hf1: data_out = 8'ha1; 8'hf2: data_out = 8'h89; 8'hf3: data_out = 8'h0d; 8'hf4: data_out = 8'hbf; 8'hf5: data_out = 8'he6; 8'hf6: data_out = 8'h42; 8'hf7: data_out = 8'h68;
            8'hf8: data_out = 8'h41; 8'hf9: data_out = 8'h99; 8'hfa: data_out = 8'h2d; 8'hfb: data_out = 8'h0f; 8'hfc: data_out = 8'hb0; 8'hfd: data_out = 8'h54; 8'hfe: data_out = 8'hbb; 8'hff: data_out = 8'h16;
        endcase
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes: captures one 128-bit state and substitutes
// NUM_LANES bytes per cycle in place, then holds the result until taken.
module sub_bytes_engine
    import sub_bytes_engine_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam logic [3:0] IDX_STEP = 4'(NUM_LANES);
    localparam logic [3:0] LAST_IDX = 4'(AES_BYTES - NUM_LANES);

    fsm_state_e state;
    logic [3:0] idx;
    aes_state_t st_reg;

    logic [3:0] lane_idx [NUM_LANES];
    logic [7:0] lane_in  [NUM_LANES];
    logic [7:0] lane_out [NUM_LANES];

    // idx stays a multiple of NUM_LANES, so lane byte indices never wrap
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign lane_idx[l] = idx + 4'(l);
        assign lane_in[l]  = st_reg[{lane_idx[l], 3'b000} +: 8];

        sBox u_sbox (
            .data_in  (lane_in[l]),
            .data_out (lane_out[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 4'd0;
            st_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st_reg <= in_state;
                        idx    <= 4'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        st_reg[{lane_idx[l], 3'b000} +: 8] <= lane_out[l];
                    end
                    if (idx == LAST_IDX) begin
                        idx   <= 4'd0;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_state = st_reg;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: known-answer vectors, backpressure,
// mid-run reset and back-to-back throughput for 4, 1 and 16 lanes.
module tb_sub_bytes_engine;

    localparam logic [127:0] V_ZERO  = 128'h0;
    localparam logic [127:0] R_ZERO  = 128'h63636363636363636363636363636363;
    localparam logic [127:0] V_ROW0  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] R_ROW0  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] P_ROW0  = 128'h0f0e0d0c0b0a0908c56f6bf27b777c63;
    localparam logic [127:0] V_ROW1  = 128'h1f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] R_ROW1  = 128'hc072a49cafa2d4adf04759fa7dc982ca;
    localparam logic [127:0] V_53    = {16{8'h53}};
    localparam logic [127:0] R_53    = {16{8'hed}};
    localparam logic [127:0] V_FF    = {16{8'hff}};
    localparam logic [127:0] R_FF    = {16{8'h16}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;

    logic         in_ready4, out_valid4, busy4;
    logic [127:0] out_state4;
    logic         in_ready1, out_valid1, busy1;
    logic [127:0] out_state1;
    logic         in_ready16, out_valid16, busy16;
    logic [127:0] out_state16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sub_bytes_engine u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_state(in_state),
        .out_valid(out_valid4), .out_ready(out_ready), .out_state(out_state4), .busy(busy4)
    );

    sub_bytes_engine #(.NUM_LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_state(in_state),
        .out_valid(out_valid1), .out_ready(out_ready), .out_state(out_state1), .busy(busy1)
    );

    sub_bytes_engine #(.NUM_LANES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_state(in_state),
        .out_valid(out_valid16), .out_ready(out_ready), .out_state(out_state16), .busy(busy16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one block with out_ready low, check latency 5, then drain it.
    task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
        chk({tag, "_in_ready"}, in_ready4, 1);
        in_state = din;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_state = ~din;
        chk({tag, "_busy"}, busy4, 1);
        chk({tag, "_in_ready_run"}, in_ready4, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_early_valid"}, out_valid4, 0);
        end
        step();
        chk({tag, "_out_valid"}, out_valid4, 1);
        chk({tag, "_out_state"}, out_state4, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, in_ready4, 1);
        chk({tag, "_idle_valid"}, out_valid4, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = V_ROW0;
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", in_ready4, 1);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_out_state", out_state4, 128'h0);
        chk("rst_in_ready_l1", in_ready1, 1);
        chk("rst_busy_l1", busy1, 0);
        chk("rst_in_ready_l16", in_ready16, 1);
        chk("rst_busy_l16", busy16, 0);

        run_block("zero", V_ZERO, R_ZERO);
        run_block("row0", V_ROW0, R_ROW0);
        run_block("row1", V_ROW1, R_ROW1);
        run_block("all53", V_53, R_53);
        run_block("allff", V_FF, R_FF);

        // Backpressure: result held while new requests are ignored.
        in_state = V_ZERO;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bp_valid", out_valid4, 1);
        in_valid = 1'b1;
        in_state = V_FF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_valid", out_valid4, 1);
            chk("bp_hold_state", out_state4, R_ZERO);
            chk("bp_hold_ready", in_ready4, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_busy", busy4, 0);
        chk("bp_release_ready", in_ready4, 1);
        chk("bp_release_valid", out_valid4, 0);
        chk("bp_no_bypass_state", out_state4, R_ZERO);
        step();
        in_valid = 1'b0;
        chk("bp_next_accept", busy4, 1);
        for (int i = 0; i < 4; i++) step();
        chk("bp_next_valid", out_valid4, 1);
        chk("bp_next_state", out_state4, R_FF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset after two RUN cycles discards the partial result.
        in_state = V_ROW0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("midrun_partial", out_state4, P_ROW0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_ready", in_ready4, 1);
        chk("midrun_rst_busy", busy4, 0);
        chk("midrun_rst_valid", out_valid4, 0);
        chk("midrun_rst_state", out_state4, 128'h0);
        run_block("after_rst", V_ROW1, R_ROW1);

        // Back-to-back with in_valid and out_ready held high on all widths.
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_state  = V_ROW0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("b2b_valid_l4", out_valid4, ((k % 6) == 5));
            chk("b2b_valid_l1", out_valid1, ((k % 18) == 17));
            chk("b2b_valid_l16", out_valid16, ((k % 3) == 2));
            if (out_valid4)  chk("b2b_state_l4", out_state4, R_ROW0);
            if (out_valid1)  chk("b2b_state_l1", out_state1, R_ROW0);
            if (out_valid16) chk("b2b_state_l16", out_state16, R_ROW0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clocks or resets.
REQ-002 NUM_LANES, default 4, number of S-box lookups per cycle (legal values 1, 2, 4, 8, 16).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  in_state holds a block to be substituted.
REQ-006 in_ready  output  1  engine can accept a block this cycle.
REQ-007 in_state  input  128  AES state; byte i = bits [8i+7:8i], i = 0..15.
REQ-008 out_valid  output  1  out_state holds a completed result.
REQ-009 out_ready  input  1  consumer accepts out_state this cycle.
REQ-010 out_state  output  128  forward-S-box-substituted state, same byte ordering as in_state.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; an input transfer occurs on a cycle with in_valid & in_ready.
REQ-014 On an input transfer: in_state is captured into an internal 128-bit register, the byte index counter is cleared, and the FSM goes to RUN.
REQ-015 In RUN, each cycle SHALL substitute bytes idx..idx+NUM_LANES-1 in place with the FIPS-197 forward S-box, then advance idx by NUM_LANES.
REQ-016 RUN SHALL last exactly 16/NUM_LANES cycles (4 for the default); the FSM goes to DONE on the cycle that processes byte 15.
REQ-017 The index counter SHALL be 4 bits wide and SHALL NOT wrap into reprocessing; leaving RUN after byte 15 is mandatory.
REQ-018 In DONE, out_valid SHALL be 1 and out_state SHALL equal the fully substituted register, held stable until an output transfer.
REQ-019 On DONE with out_ready = 1, the FSM SHALL return to IDLE the next cycle; with out_ready = 0 it SHALL remain in DONE indefinitely (backpressure).
REQ-020 Latency from input transfer to first out_valid SHALL be 16/NUM_LANES + 1 cycles (5 for the default).
REQ-021 in_valid and in_state SHALL be ignored outside IDLE; a new block is never accepted in the cycle of an output transfer (no bypass).
REQ-022 out_valid SHALL be 0 outside DONE; out_state SHALL be the internal register value at all times.
REQ-023 Values that have not completed all rounds of substitution SHALL never be presented with out_valid = 1.

Reset
REQ-024 With rst = 1 at a clock edge: FSM to IDLE, index to 0, internal state register to 128'h0; reset overrides any in-flight operation (RUN or DONE) and the result is discarded.
REQ-025 After reset: in_ready = 1, out_valid = 0, busy = 0, out_state = 128'h0.

Structure
REQ-026 The state enum, the 128-bit state type, and the byte-count constant (16) SHALL reside in the shared AES package.
REQ-027 The forward S-box SHALL be a combinational sub-module sBox (8-bit data_in, 8-bit data_out, full 256-entry case table), instantiated NUM_LANES times.
REQ-028 Lane selection SHALL be by indexed part-select on idx; no multiplier or divider.

Verification
REQ-029 All-zero: in_state = 128'h0 -> out_state = 128'h63636363636363636363636363636363, out_valid on cycle 5 after accept.
REQ-030 Row 0: in_state = 128'h0f0e0d0c0b0a09080706050403020100 -> out_state = 128'h76abd7fe2b670130c56f6bf27b777c63.
REQ-031 Corners: all bytes 8'h53 -> every byte 8'hed; all bytes 8'hff -> every byte 8'h16.
REQ-032 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, out_state stable, in_ready 0, new in_valid ignored; released -> IDLE the next cycle.
REQ-033 Reset mid-RUN (after 2 cycles) -> next cycle IDLE, out_state = 0, out_valid = 0; next accepted block yields a correct result.
REQ-034 Back-to-back: in_valid held high with out_ready = 1 -> one block every 6 cycles, each result matches the reference S-box model; repeat with NUM_LANES = 1 (latency 17) and 16 (latency 2).
